// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding for the bit-serial adder controller.
//   ST_W    : state register width
//   state_t : ST_IDLE / ST_RUN / ST_DONE (2'd3 is unused and recovers to IDLE)
package serial_adder_pkg;
    localparam int ST_W = 2;
    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_adder_ctrl_full_adder_cell.sv
// full_adder_cell: 1-bit full adder built from two half adders plus an OR for the carry.
//   halfAdder      : i_a, i_b -> o_s (sum), o_c (carry)
//   full_adder_cell: a, b, ci -> s (sum), co (carry-out)
module halfAdder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic w_s0, w_c0, w_c1;
    halfAdder u_ha0 (.i_a(a),    .i_b(b),  .o_s(w_s0), .o_c(w_c0));
    halfAdder u_ha1 (.i_a(w_s0), .i_b(ci), .o_s(s),    .o_c(w_c1));
    assign co = w_c0 | w_c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sharing one full_adder_cell over WIDTH cycles.
//   clk, rst_n     : rising-edge clock, async active-low reset
//   start, a, b, cin : request and operands, captured while ready
//   ready/busy/done  : IDLE / RUN / one-cycle DONE, decoded from state
//   sum, cout        : result, held until the next accepted add completes
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_res, r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry, r_cout;
    logic             w_s, w_c, w_last;
    logic [WIDTH-1:0] w_res_next;
    full_adder_cell u_cell (.a(r_a[0]), .b(r_b[0]), .ci(r_carry), .s(w_s), .co(w_c));
    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB;
    // written as shifts so WIDTH=1 needs no special-case slice.
    assign w_res_next = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
    assign w_last     = r_cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_a     <= a;
                    r_b     <= b;
                    r_carry <= cin;
                    r_cnt   <= '0;
                    r_res   <= '0;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_res   <= w_res_next;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_c;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign ready = r_state == ST_IDLE;
    assign busy  = r_state == ST_RUN;
    assign done  = r_state == ST_DONE;
    assign sum   = r_sum;
    assign cout  = r_cout;
endmodule
